instr_encode: RTL and testbench

Sequential RV32I instruction encoder, the inverse of the core's field/immediate decoder. It accepts instruction fields plus a 32-bit immediate and an instruction-type code, and packs them into a 32-bit RV32I instruction word. Results go through a 2-entry output FIFO with valid/ready handshakes on both sides. Used by the self-test program generator and the debug instruction-injection path, both of which feed the fetch/decode stage.

---
 rtl/instr_encode.sv | 139 +++++++++++++
 tb/tb_instr_encode.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encode.sv
// RV32I instruction encoder: packs fields and immediate into a 32-bit word behind a 2-entry output FIFO.
// Optional immediate range checking is enabled by defining INSTR_ENCODE_IMM_CHECK_EN.
module instr_encode (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  inst_type,
    input  logic [6:0]  opcode,
    input  logic [4:0]  rd_addr,
    input  logic [2:0]  funct3,
    input  logic [4:0]  rs1_addr,
    input  logic [4:0]  rs2_addr,
    input  logic [6:0]  funct7,
    input  logic [31:0] immediate,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] instruction,
    output logic        out_err
);

    // Shared instruction-format codes (mirrors defines.v)
    localparam logic [3:0] TYPE_R       = 4'd0;
    localparam logic [3:0] TYPE_I       = 4'd1;
    localparam logic [3:0] TYPE_S       = 4'd2;
    localparam logic [3:0] TYPE_B       = 4'd3;
    localparam logic [3:0] TYPE_U       = 4'd4;
    localparam logic [3:0] TYPE_J       = 4'd5;
    localparam logic [3:0] TYPE_INVALID = 4'd15;

    // Returns {err, word}; unknown formats yield a zero word with the error flag set.
    function automatic logic [32:0] encode(
        input logic [3:0]  t,
        input logic [6:0]  op,
        input logic [4:0]  rd,
        input logic [2:0]  f3,
        input logic [4:0]  rs1,
        input logic [4:0]  rs2,
        input logic [6:0]  f7,
        input logic [31:0] imm
    );
        logic [31:0] word;
        logic        err;
        word = 32'h0000_0000;
        err  = 1'b0;
        case (t)
            TYPE_R: word = {f7, rs2, rs1, f3, rd, op};
            TYPE_I: begin
                word = {imm[11:0], rs1, f3, rd, op};
`ifdef INSTR_ENCODE_IMM_CHECK_EN
                err = !((&imm[31:11]) || (~|imm[31:11]));
`endif
            end
            TYPE_S: begin
                word = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
`ifdef INSTR_ENCODE_IMM_CHECK_EN
                err = !((&imm[31:11]) || (~|imm[31:11]));
`endif
            end
            TYPE_B: begin
                word = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
`ifdef INSTR_ENCODE_IMM_CHECK_EN
                err = imm[0] || !((&imm[31:12]) || (~|imm[31:12]));
`endif
            end
            TYPE_U: begin
                word = {imm[31:12], rd, op};
`ifdef INSTR_ENCODE_IMM_CHECK_EN
                err = |imm[11:0];
`endif
            end
            TYPE_J: begin
                word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
`ifdef INSTR_ENCODE_IMM_CHECK_EN
                err = imm[0] || !((&imm[31:20]) || (~|imm[31:20]));
`endif
            end
            default: begin
                word = 32'h0000_0000;
                err  = 1'b1;
            end
        endcase
        return {err, word};
    endfunction

    logic [31:0] word_mem_r [0:1];
    logic        err_mem_r  [0:1];
    logic        wr_ptr_r;
    logic        rd_ptr_r;
    logic [1:0]  count_r;
    logic        push_s;
    logic        pop_s;
    logic [32:0] enc_s;

    assign enc_s     = encode(inst_type, opcode, rd_addr, funct3, rs1_addr, rs2_addr, funct7, immediate);
    assign out_valid = (count_r != 2'd0);
    assign in_ready  = (count_r != 2'd2) || out_ready;
    assign push_s    = in_valid && in_ready;
    assign pop_s     = out_valid && out_ready;

    // Head outputs are gated so stale, unreset storage never leaks out
    always_comb begin
        instruction = 32'h0000_0000;
        out_err     = 1'b0;
        if (out_valid) begin
            instruction = word_mem_r[rd_ptr_r];
            out_err     = err_mem_r[rd_ptr_r];
        end else begin
            instruction = 32'h0000_0000;
            out_err     = 1'b0;
        end
    end

    // Entry storage: written at the tail on push, deliberately not reset
    always_ff @(posedge clk) begin
        if (push_s) begin
            word_mem_r[wr_ptr_r] <= enc_s[31:0];
            err_mem_r[wr_ptr_r]  <= enc_s[32];
        end
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= 1'b0;
            rd_ptr_r <= 1'b0;
            count_r  <= 2'd0;
        end else begin
            if (push_s) wr_ptr_r <= ~wr_ptr_r;
            if (pop_s)  rd_ptr_r <= ~rd_ptr_r;
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + 2'd1;
                2'b01:   count_r <= count_r - 2'd1;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_encode.sv
// Self-checking bench for instr_encode: arithmetic reference model, queue scoreboard, directed and random stimulus.
module tb_instr_encode;

    localparam logic [3:0] T_R = 4'd0, T_I = 4'd1, T_S = 4'd2, T_B = 4'd3,
                           T_U = 4'd4, T_J = 4'd5, T_INV = 4'd15;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  inst_type = 4'd0;
    logic [6:0]  opcode = 7'd0;
    logic [4:0]  rd_addr = 5'd0;
    logic [2:0]  funct3 = 3'd0;
    logic [4:0]  rs1_addr = 5'd0;
    logic [4:0]  rs2_addr = 5'd0;
    logic [6:0]  funct7 = 7'd0;
    logic [31:0] immediate = 32'd0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] instruction;
    logic        out_err;

    int errors = 0;
    int checks = 0;
    logic [32:0] q [$];

    instr_encode dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .inst_type(inst_type), .opcode(opcode), .rd_addr(rd_addr), .funct3(funct3),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .funct7(funct7), .immediate(immediate),
        .out_valid(out_valid), .out_ready(out_ready), .instruction(instruction), .out_err(out_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: place each field by shift-and-mask arithmetic; range rules on signed integers
    function automatic logic [32:0] model(input logic [3:0] t, input logic [6:0] op, input logic [4:0] rd,
                                          input logic [2:0] f3, input logic [4:0] rs1, input logic [4:0] rs2,
                                          input logic [6:0] f7, input logic [31:0] imm);
        logic [31:0] w;
        logic        e;
        int          si;
        si = $signed(imm);
        w = 32'(op);
        e = 1'b0;
        case (t)
            T_R: w = w | (32'(rd) << 7) | (32'(f3) << 12) | (32'(rs1) << 15) | (32'(rs2) << 20) | (32'(f7) << 25);
            T_I: begin
                w = w | (32'(rd) << 7) | (32'(f3) << 12) | (32'(rs1) << 15) | ((imm & 32'hFFF) << 20);
                e = (si < -2048) || (si > 2047);
            end
            T_S: begin
                w = w | ((imm & 32'h1F) << 7) | (32'(f3) << 12) | (32'(rs1) << 15) | (32'(rs2) << 20)
                      | (((imm >> 5) & 32'h7F) << 25);
                e = (si < -2048) || (si > 2047);
            end
            T_B: begin
                w = w | (((imm >> 11) & 32'h1) << 7) | (((imm >> 1) & 32'hF) << 8) | (32'(f3) << 12)
                      | (32'(rs1) << 15) | (32'(rs2) << 20) | (((imm >> 5) & 32'h3F) << 25)
                      | (((imm >> 12) & 32'h1) << 31);
                e = (si % 2 != 0) || (si < -4096) || (si > 4094);
            end
            T_U: begin
                w = w | (32'(rd) << 7) | (imm & 32'hFFFF_F000);
                e = (imm % 32'd4096) != 32'd0;
            end
            T_J: begin
                w = w | (32'(rd) << 7) | (((imm >> 12) & 32'hFF) << 12) | (((imm >> 11) & 32'h1) << 20)
                      | (((imm >> 1) & 32'h3FF) << 21) | (((imm >> 20) & 32'h1) << 31);
                e = (si % 2 != 0) || (si < -1048576) || (si > 1048574);
            end
            default: begin
                w = 32'd0;
                e = 1'b1;
            end
        endcase
`ifndef INSTR_ENCODE_IMM_CHECK_EN
        if (t <= T_J) e = 1'b0;
`endif
        return {e, w};
    endfunction

    // Compare process: check outputs mid-cycle, then advance the scoreboard across the coming edge
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            chk("rst_out_valid", 32'(out_valid), 32'd0);
            chk("rst_in_ready", 32'(in_ready), 32'd1);
            chk("rst_instruction", instruction, 32'd0);
            chk("rst_out_err", 32'(out_err), 32'd0);
        end else begin
            chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
            chk("in_ready", 32'(in_ready), 32'((q.size() != 2) || out_ready));
            if (q.size() != 0) begin
                chk("instruction", instruction, q[0][31:0]);
                chk("out_err", 32'(out_err), 32'(q[0][32]));
            end
            if (q.size() != 0 && out_ready) void'(q.pop_front());
            if (in_valid && ((q.size() != 2) || out_ready))
                q.push_back(model(inst_type, opcode, rd_addr, funct3, rs1_addr, rs2_addr, funct7, immediate));
        end
    end

    task automatic drive(input logic [3:0] t, input logic [6:0] op, input logic [4:0] rd, input logic [2:0] f3,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic [6:0] f7, input logic [31:0] imm);
        inst_type = t; opcode = op; rd_addr = rd; funct3 = f3;
        rs1_addr = rs1; rs2_addr = rs2; funct7 = f7; immediate = imm;
        in_valid = 1'b1;
    endtask

    // Present one request (starting at posedge+1), wait for acceptance, return at accept edge +1
    task automatic send(input logic [3:0] t, input logic [6:0] op, input logic [4:0] rd, input logic [2:0] f3,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [6:0] f7, input logic [31:0] imm);
        logic acc;
        int   n;
        drive(t, op, rd, f3, rs1, rs2, f7, imm);
        acc = 1'b0;
        n = 0;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n = n + 1;
        end
        in_valid = 1'b0;
        if (!acc) chk("accept_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        logic [32:0] m;
        logic        exp_e;
        int          sel;
        logic [3:0]  rt;
        logic [31:0] ri;

        // Pin the reference model to hand-computed words
        m = model(T_I, 7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd5);
        chk("model_I", m[31:0], 32'h0050_0093);
        m = model(T_S, 7'h23, 5'd0, 3'd2, 5'd1, 5'd2, 7'd0, 32'd8);
        chk("model_S", m[31:0], 32'h0020_A423);
        m = model(T_B, 7'h63, 5'd0, 3'd0, 5'd1, 5'd2, 7'd0, -32'sd4);
        chk("model_B", m[31:0], 32'hFE20_8EE3);
        m = model(T_J, 7'h6F, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd2048);
        chk("model_J", m[31:0], 32'h0010_00EF);

        #3;
        chk("init_out_valid", 32'(out_valid), 32'd0);
        chk("init_in_ready", 32'(in_ready), 32'd1);
        #20 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed encodings with the consumer always ready: result visible one cycle after acceptance
        out_ready = 1'b1;
        send(T_I, 7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 7'h7F, 32'd5);
        chk("I_word", instruction, 32'h0050_0093);
        chk("I_err", 32'(out_err), 32'd0);
        chk("I_valid", 32'(out_valid), 32'd1);
        send(T_S, 7'h23, 5'd0, 3'd2, 5'd1, 5'd2, 7'd0, 32'd8);
        chk("S_word", instruction, 32'h0020_A423);
        send(T_U, 7'h37, 5'd5, 3'd0, 5'd0, 5'd31, 7'd0, 32'h1234_5000);
        chk("U_word", instruction, 32'h1234_52B7);
        send(T_B, 7'h63, 5'd0, 3'd0, 5'd1, 5'd2, 7'd0, 32'hFFFF_FFFC);
        chk("B_word", instruction, 32'hFE20_8EE3);
        send(T_J, 7'h6F, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd2048);
        chk("J_word", instruction, 32'h0010_00EF);
        send(T_R, 7'h33, 5'd3, 3'd0, 5'd1, 5'd2, 7'h20, 32'd0);
        chk("R_word", instruction, 32'h4020_81B3);

        // Error cases
        send(T_INV, 7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd5);
        chk("inv_word", instruction, 32'd0);
        chk("inv_err", 32'(out_err), 32'd1);
`ifdef INSTR_ENCODE_IMM_CHECK_EN
        exp_e = 1'b1;
`else
        exp_e = 1'b0;
`endif
        send(T_I, 7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd2048);
        chk("I_range_err", 32'(out_err), 32'(exp_e));
        chk("I_range_word", instruction, 32'h8000_0093);
        send(T_B, 7'h63, 5'd0, 3'd0, 5'd1, 5'd2, 7'd0, 32'd3);
        chk("B_odd_err", 32'(out_err), 32'(exp_e));

        // Backpressure: two accepted, third stalls until out_ready rises
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        drive(T_I, 7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd1);
        @(negedge clk);
        chk("bp_rdy0", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        drive(T_I, 7'h13, 5'd2, 3'd0, 5'd0, 5'd0, 7'd0, 32'd2);
        @(negedge clk);
        chk("bp_rdy1", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        drive(T_I, 7'h13, 5'd3, 3'd0, 5'd0, 5'd0, 7'd0, 32'd3);
        @(negedge clk);
        chk("bp_rdy2", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        chk("bp_hold_word", instruction, 32'h0010_0093);
        out_ready = 1'b1;
        #1;
        chk("bp_ready_comb", 32'(in_ready), 32'd1);
        chk("bp_first", instruction, 32'h0010_0093);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("bp_second", instruction, 32'h0020_0113);
        @(posedge clk);
        #1;
        chk("bp_third", instruction, 32'h0030_0193);
        @(posedge clk);
        #1;
        chk("bp_drained", 32'(out_valid), 32'd0);

        // Asynchronous reset mid-cycle with two entries queued
        out_ready = 1'b0;
        send(T_U, 7'h37, 5'd4, 3'd0, 5'd0, 5'd0, 7'd0, 32'hABCD_E000);
        send(T_U, 7'h37, 5'd6, 3'd0, 5'd0, 5'd0, 7'd0, 32'h1111_1000);
        chk("pre_rst_full", 32'(in_ready), 32'd0);
        #1 rst_n = 1'b0;
        #1;
        chk("ar_out_valid", 32'(out_valid), 32'd0);
        chk("ar_in_ready", 32'(in_ready), 32'd1);
        chk("ar_instruction", instruction, 32'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(T_I, 7'h13, 5'd7, 3'd0, 5'd0, 5'd0, 7'd0, 32'd9);
        chk("post_rst_word", instruction, 32'h0090_0393);
        @(posedge clk);
        #1;
        chk("post_rst_alone", 32'(out_valid), 32'd0);

        // Randomized traffic, checked by the compare process
        for (int i = 0; i < 600; i++) begin
            sel = $urandom_range(0, 7);
            rt = (sel < 6) ? 4'(sel) : 4'($urandom_range(6, 15));
            case ($urandom_range(0, 3))
                0: ri = $urandom;
                1: ri = 32'($urandom_range(0, 8191)) - 32'd4096;
                2: ri = 32'($urandom_range(0, 3)) + ((($urandom_range(0, 1)) != 0) ? 32'd2046 : 32'hFFFF_F7FE);
                default: ri = $urandom & 32'hFFFF_F000;
            endcase
            inst_type = rt;
            opcode = 7'($urandom);
            rd_addr = 5'($urandom);
            funct3 = 3'($urandom);
            rs1_addr = 5'($urandom);
            rs2_addr = 5'($urandom);
            funct7 = 7'($urandom);
            immediate = ri;
            in_valid = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("final_empty", 32'(out_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
